// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
//   state_e       : divider control states
//   cnt_w()       : step-counter width able to hold the value WIDTH
//   DBZ_QUOT_BIT  : bit replicated across the quotient on divide-by-zero
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DBZ_QUOT_BIT = 1'b1;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_lzc.sv
// Leading-zero counter used to pre-normalise the dividend for early exit.
//   data    : value to inspect
//   count_c : number of leading zeros (WIDTH when data is zero), combinational
module lzc
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count_c
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count_c = CNT_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data[i]) count_c = CNT_W'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with registered results.
// Optional macro DIV_EARLY_EXIT_EN: pre-normalise the dividend and run only
// bitlen(dividend) steps (one step on divide-by-zero); results are unchanged.
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, honoured only while busy is low
//   dividend, divisor   : operands, captured with start
//   busy                : operation in flight (RUN or DONE)
//   quotient, remainder : last completed result, held until the next one
//   finish              : one-cycle completion pulse
//   div_by_zero         : set with finish when the divisor was zero
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] dvd, dvd_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic [WIDTH-1:0] quot_n, remd_n;
  logic             busy_n, finish_n, dbz_n;

  logic [WIDTH+1:0] trial_c;
  logic             borrow_c;
  logic [WIDTH-1:0] load_shreg_c;
  logic [CNT_W-1:0] load_cnt_c;

`ifdef DIV_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz_c;

  lzc #(.WIDTH(WIDTH)) u_lzc (
    .data    (dividend),
    .count_c (lz_c)
  );

  // Skip the leading zeros; a zero dividend or zero divisor still takes one step.
  always_comb begin
    load_shreg_c = dividend << lz_c;
    if (divisor == '0 || lz_c == CNT_W'(WIDTH)) load_cnt_c = CNT_W'(1);
    else                                        load_cnt_c = CNT_W'(WIDTH) - lz_c;
  end
`else
  assign load_shreg_c = dividend;
  assign load_cnt_c   = CNT_W'(WIDTH);
`endif

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign trial_c  = {rem, shreg[WIDTH-1]} - (WIDTH+2)'(dvs);
  assign borrow_c = trial_c[WIDTH+1];

  // Next-state and datapath update.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    shreg_n  = shreg;
    dvd_n    = dvd;
    dvs_n    = dvs;
    quot_n   = quotient;
    remd_n   = remainder;
    dbz_n    = div_by_zero;
    busy_n   = busy;
    finish_n = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          busy_n  = 1'b1;
          dvd_n   = dividend;
          dvs_n   = divisor;
          shreg_n = load_shreg_c;
          rem_n   = '0;
          cnt_n   = load_cnt_c;
        end
      end
      RUN: begin
        // Quotient bits enter at the LSB as dividend bits leave at the MSB.
        shreg_n = {shreg[WIDTH-2:0], ~borrow_c};
        if (!borrow_c) rem_n = trial_c[WIDTH:0];
        else           rem_n = {rem[WIDTH-1:0], shreg[WIDTH-1]};
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n  = DONE;
          finish_n = 1'b1;
          if (dvs == '0) begin
            quot_n = {WIDTH{DBZ_QUOT_BIT}};
            remd_n = dvd;
            dbz_n  = 1'b1;
          end else begin
            quot_n = shreg_n;
            remd_n = rem_n[WIDTH-1:0];
            dbz_n  = 1'b0;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      shreg       <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rem         <= rem_n;
      shreg       <= shreg_n;
      dvd         <= dvd_n;
      dvs         <= dvs_n;
      quotient    <= quot_n;
      remainder   <= remd_n;
      div_by_zero <= dbz_n;
      busy        <= busy_n;
      finish      <= finish_n;
    end
  end

endmodule
